// File: rtl/pipeline_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_if_pkg
// Purpose  : Shared defaults and the fetch-entry type for the instruction
//            fetch stage (pipeline_if_gen and its FIFOs).
// Contents : DEF_XLEN, DEF_RESET_PC, DEF_PC_STEP, fetch_entry_t {pc, inst}
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_if_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_PC_STEP  = 4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_if_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_if_gen_if
// Purpose  : Bundles the instruction-memory request/response bus and the
//            fetch-to-decode valid/ready bus of the fetch stage.
// Modports : master - fetch stage (drives imem_req/addr, id_valid/pc/inst)
//            slave  - environment (drives imem_gnt/rvalid/rdata, id_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_if_gen_if
  import pipeline_if_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid, id_pc, id_inst,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid, id_pc, id_inst,
    output id_ready
  );

endinterface
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_fifo
// Purpose  : Small synchronous FIFO with flush and occupancy count.
//            DEPTH must be a power of two (pointers wrap naturally).
// Ports    : clk, rst_n (async, active-low), flush (clears contents,
//            wins over push/pop), push/wdata, pop/rdata (head, show-ahead),
//            count (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     flush,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         wdata,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         rdata,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != '0);
  // A push into a full FIFO is accepted only when a pop frees a slot.
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; consumers qualify rdata with count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;

endmodule
`default_nettype wire

// File: rtl/pipeline_if_gen.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_if_gen
// Purpose  : Instruction fetch stage. Issues in-order requests to instruction
//            memory under a credit limit, tracks request PCs, buffers returned
//            instructions in a fetch queue and hands them to decode. A
//            redirect reloads the PC, flushes the queue and drops responses
//            still in flight.
// Ports    : clk_IF, rst_IF (async, active-low), en_IF (fetch enable),
//            PCSrc / PC_in_IF (redirect), PC_out_IF (current fetch PC),
//            bus (pipeline_if_gen_if.master: imem_* and id_* signals)
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_if_gen
  import pipeline_if_pkg::*;
#(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int              PC_STEP  = DEF_PC_STEP,
  parameter int              FQ_DEPTH = 2
) (
  input  wire logic            clk_IF,
  input  wire logic            rst_IF,
  input  wire logic            en_IF,
  input  wire logic            PCSrc,
  input  wire logic [XLEN-1:0] PC_in_IF,
  output logic      [XLEN-1:0] PC_out_IF,
  pipeline_if_gen_if.master    bus
);

  localparam int            CW     = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0]   CREDIT = (CW + 1)'(FQ_DEPTH);

  logic [XLEN-1:0]   pc;
  logic              req_held;
  logic              req;
  logic              grant;
  logic              rsp;
  logic              keep;
  logic              credit_ok;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fq_count;
  logic [CW-1:0]     drop_cnt;
  logic [XLEN-1:0]   pend_pc;
  logic [2*XLEN-1:0] fq_head;
  logic              id_valid_w;
  logic              unused_pc_lsbs;

  // Redirect targets are forced word aligned, so the low bits never matter.
  assign unused_pc_lsbs = ^PC_in_IF[1:0];

  // In-flight requests plus queued entries may never exceed the queue depth,
  // which is what keeps the fetch queue from overflowing.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fq_count}) < CREDIT;

  // A request already presented stays up until granted, independent of
  // en_IF and credit; only a redirect withdraws it. Reset gates it directly
  // so it drops asynchronously.
  assign req   = rst_IF && !PCSrc && (req_held || (en_IF && credit_ok));
  assign grant = req && bus.imem_gnt;

  // Responses with nothing outstanding (e.g. after a reset) are stray.
  assign rsp  = bus.imem_rvalid && (outstanding != '0);
  assign keep = rsp && (drop_cnt == '0);

  always_ff @(posedge clk_IF or negedge rst_IF) begin
    if (!rst_IF) begin
      pc       <= RESET_PC;
      req_held <= 1'b0;
      drop_cnt <= '0;
    end else begin
      req_held <= req && !bus.imem_gnt;
      if (PCSrc) begin
        pc       <= {PC_in_IF[XLEN-1:2], 2'b00};
        // Everything still in flight after this edge belongs to the old path.
        drop_cnt <= outstanding + CW'(grant) - CW'(rsp);
      end else begin
        if (grant) pc <= pc + XLEN'(PC_STEP);
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Pending-PC FIFO: its occupancy is the outstanding-request count.
  if_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (XLEN)
  ) u_pend_fifo (
    .clk   (clk_IF),
    .rst_n (rst_IF),
    .flush (1'b0),
    .push  (grant),
    .wdata (pc),
    .pop   (rsp),
    .rdata (pend_pc),
    .count (outstanding)
  );

  // Fetch queue: {pc, inst}; a redirect flushes it and overrides push/pop.
  if_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fetch_q (
    .clk   (clk_IF),
    .rst_n (rst_IF),
    .flush (PCSrc),
    .push  (keep),
    .wdata ({pend_pc, bus.imem_rdata}),
    .pop   (id_valid_w && bus.id_ready),
    .rdata (fq_head),
    .count (fq_count)
  );

  assign id_valid_w    = (fq_count != '0);
  assign bus.id_valid  = id_valid_w;
  assign bus.id_pc     = id_valid_w ? fq_head[2*XLEN-1:XLEN] : '0;
  assign bus.id_inst   = id_valid_w ? fq_head[XLEN-1:0]      : '0;
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign PC_out_IF     = pc;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_if_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_if_gen
// Purpose  : Self-checking bench for pipeline_if_gen. Main instance uses the
//            default depth of 2; a depth-4 instance sustains one instruction
//            per cycle for streaming; a third instance starts at the top of
//            the address space to exercise PC wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_if_gen;
  import pipeline_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_out, pc_out_s, pc_out_w;

  always #5 clk = ~clk;

  pipeline_if_gen_if #(.XLEN(32)) bus   ();
  pipeline_if_gen_if #(.XLEN(32)) bus_s ();
  pipeline_if_gen_if #(.XLEN(32)) bus_w ();

  pipeline_if_gen #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4), .FQ_DEPTH(2)) dut (
    .clk_IF(clk), .rst_IF(rst_n), .en_IF(en), .PCSrc(pcsrc),
    .PC_in_IF(pc_in), .PC_out_IF(pc_out), .bus(bus));

  pipeline_if_gen #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4), .FQ_DEPTH(4)) dut_s (
    .clk_IF(clk), .rst_IF(rst_n), .en_IF(en), .PCSrc(1'b0),
    .PC_in_IF(32'h0), .PC_out_IF(pc_out_s), .bus(bus_s));

  pipeline_if_gen #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4), .FQ_DEPTH(2)) dut_w (
    .clk_IF(clk), .rst_IF(rst_n), .en_IF(en), .PCSrc(1'b0),
    .PC_in_IF(32'h0), .PC_out_IF(pc_out_w), .bus(bus_w));

  int           checks = 0;
  int           errors = 0;
  int           grants = 0;
  logic [31:0]  last_gnt_addr = '0;
  bit           resp_en = 1'b0;
  fetch_entry_t exp_q [$];
  logic [31:0]  mem_q [$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // One cycle of the main instance: scoreboard consume, memory accept,
  // clock edge, then memory response (one cycle after grant, in order).
  task automatic tick();
    fetch_entry_t e;
    #1;
    if (bus.id_valid && bus.id_ready && !pcsrc) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: got id_pc=%h id_inst=%h, expected no entry", bus.id_pc, bus.id_inst);
      end else begin
        e = exp_q.pop_front();
        if (bus.id_pc !== e.pc || bus.id_inst !== e.inst) begin
          errors++;
          $display("FAIL sb_entry: got pc=%h inst=%h, expected pc=%h inst=%h",
                   bus.id_pc, bus.id_inst, e.pc, e.inst);
        end
      end
    end
    if (pcsrc) exp_q.delete();
    if (bus.imem_req && bus.imem_gnt) begin
      grants++;
      last_gnt_addr = bus.imem_addr;
      mem_q.push_back(bus.imem_addr);
      e.pc   = bus.imem_addr;
      e.inst = data_of(bus.imem_addr);
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (resp_en && mem_q.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data_of(mem_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; pcsrc = 1'b0; pc_in = '0; resp_en = 1'b0;
    bus.imem_gnt = 0;   bus.imem_rvalid = 0;   bus.imem_rdata = '0;   bus.id_ready = 0;
    bus_s.imem_gnt = 0; bus_s.imem_rvalid = 0; bus_s.imem_rdata = '0; bus_s.id_ready = 0;
    bus_w.imem_gnt = 0; bus_w.imem_rvalid = 0; bus_w.imem_rdata = '0; bus_w.id_ready = 0;
    exp_q.delete(); mem_q.delete(); grants = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(output int left);
    en = 1'b0; pcsrc = 1'b0; bus.imem_gnt = 1'b1; resp_en = 1'b1; bus.id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0 && !bus.imem_rvalid) break;
      tick();
    end
    left = exp_q.size();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, expected 0", bus.imem_req); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h, expected 0", bus.id_pc); end
    checks++; if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL rst_id_inst: got %h, expected 0", bus.id_inst); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out: got %h, expected 0", pc_out); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h, expected 0", bus.imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h, expected 1 / 0", bus.imem_req, bus.imem_addr); end
    en = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] smem [$];
    logic [31:0] exp_pc;
    do_reset();
    en = 1'b1; bus_s.imem_gnt = 1'b1; bus_s.id_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (bus_s.imem_req && bus_s.imem_gnt) smem.push_back(bus_s.imem_addr);
      @(posedge clk);
      @(negedge clk);
      if (smem.size() > 0) begin
        bus_s.imem_rvalid = 1'b1; bus_s.imem_rdata = data_of(smem.pop_front());
      end else begin
        bus_s.imem_rvalid = 1'b0; bus_s.imem_rdata = '0;
      end
      if (k == 1) begin
        checks++; if (bus_s.id_valid !== 1'b0) begin
          errors++; $display("FAIL stream_latency: id_valid=%b one cycle after grant, expected 0", bus_s.id_valid); end
      end else if (k <= 5) begin
        exp_pc = 32'(4 * (k - 2));
        checks++;
        if (bus_s.id_valid !== 1'b1 || bus_s.id_pc !== exp_pc || bus_s.id_inst !== data_of(exp_pc)) begin
          errors++;
          $display("FAIL stream_seq: cycle %0d got valid=%b pc=%h inst=%h, expected 1 %h %h",
                   k, bus_s.id_valid, bus_s.id_pc, bus_s.id_inst, exp_pc, data_of(exp_pc));
        end
      end
    end
    en = 1'b0; bus_s.imem_gnt = 1'b0; bus_s.imem_rvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    int left;
    do_reset();
    en = 1'b1; bus.imem_gnt = 1'b1; resp_en = 1'b1; bus.id_ready = 1'b0;
    repeat (6) tick();
    #1;
    checks++; if (grants != 2) begin errors++; $display("FAIL bp_grants: got %0d, expected 2", grants); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b, expected 0", bus.imem_req); end
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin
      errors++; $display("FAIL bp_head: got valid=%b pc=%h, expected 1 / 0", bus.id_valid, bus.id_pc); end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 10 && grants < 3; i++) tick();
    checks++; if (grants < 3 || last_gnt_addr !== 32'h8) begin
      errors++; $display("FAIL bp_resume: got grants=%0d addr=%h, expected >=3 / 00000008", grants, last_gnt_addr); end
    repeat (6) tick();
    drain(left);
    checks++; if (left != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, expected 0", left); end
  endtask

  task automatic test_grant_hold();
    int left;
    do_reset();
    en = 1'b1; bus.imem_gnt = 1'b0; resp_en = 1'b1; bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      en = ~en;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || pc_out !== 32'h0) begin
        errors++; $display("FAIL hold_%0d: got req=%b addr=%h pc_out=%h, expected 1 / 0 / 0",
                           i, bus.imem_req, bus.imem_addr, pc_out); end
    end
    bus.imem_gnt = 1'b1;
    tick();
    #1;
    checks++; if (grants != 1 || last_gnt_addr !== 32'h0 || pc_out !== 32'h4) begin
      errors++; $display("FAIL hold_release: got grants=%0d addr=%h pc_out=%h, expected 1 / 0 / 4",
                         grants, last_gnt_addr, pc_out); end
    drain(left);
    checks++; if (left != 0) begin errors++; $display("FAIL hold_drain: got %0d pending, expected 0", left); end
  endtask

  task automatic test_redirect();
    int left;
    do_reset();
    en = 1'b1; bus.imem_gnt = 1'b1; resp_en = 1'b0; bus.id_ready = 1'b0;
    repeat (2) tick();
    checks++; if (grants != 2) begin errors++; $display("FAIL redir_outstanding: got %0d grants, expected 2", grants); end
    pcsrc = 1'b1; pc_in = 32'h0000_1003;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b, expected 0", bus.imem_req); end
    tick();
    pcsrc = 1'b0; resp_en = 1'b1; bus.id_ready = 1'b1;
    #1;
    checks++; if (bus.imem_addr !== 32'h1000 || pc_out !== 32'h1000) begin
      errors++; $display("FAIL redir_addr: got addr=%h pc_out=%h, expected 00001000", bus.imem_addr, pc_out); end
    for (int i = 0; i < 10 && bus.id_valid !== 1'b1; i++) tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h1000) begin
      errors++; $display("FAIL redir_first_pc: got valid=%b pc=%h, expected 1 / 00001000", bus.id_valid, bus.id_pc); end
    drain(left);
    checks++; if (left != 0) begin errors++; $display("FAIL redir_drain: got %0d pending, expected 0", left); end
  endtask

  task automatic test_redirect_pop();
    int left;
    do_reset();
    en = 1'b1; bus.imem_gnt = 1'b1; resp_en = 1'b1; bus.id_ready = 1'b0;
    repeat (5) tick();
    bus.id_ready = 1'b1; pcsrc = 1'b1; pc_in = 32'h0000_0200;
    tick();
    pcsrc = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, expected 0", bus.id_valid); end
    for (int i = 0; i < 10 && bus.id_valid !== 1'b1; i++) tick();
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h200) begin
      errors++; $display("FAIL flush_first_pc: got valid=%b pc=%h, expected 1 / 00000200", bus.id_valid, bus.id_pc); end
    drain(left);
    checks++; if (left != 0) begin errors++; $display("FAIL flush_drain: got %0d pending, expected 0", left); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    en = 1'b1; bus.imem_gnt = 1'b1; resp_en = 1'b1; bus.id_ready = 1'b1;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ctl: got req=%b valid=%b, expected 0 / 0", bus.imem_req, bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0) begin
      errors++; $display("FAIL mid_rst_data: got pc=%h inst=%h, expected 0 / 0", bus.id_pc, bus.id_inst); end
    checks++; if (pc_out !== 32'h0 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL mid_rst_pc: got pc_out=%h addr=%h, expected 0 / 0", pc_out, bus.imem_addr); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    exp_q.delete(); mem_q.delete(); mem_q.push_back(32'h40);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.id_valid !== 1'b0) begin
        errors++; $display("FAIL late_rvalid_%0d: got id_valid=%b, expected 0", i, bus.id_valid); end
    end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL late_pc_freeze: got %h, expected 0", pc_out); end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1; bus_w.imem_gnt = 1'b1;
    #1;
    checks++; if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first: got req=%b addr=%h, expected 1 / fffffffc", bus_w.imem_req, bus_w.imem_addr); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== 32'h0 || pc_out_w !== 32'h0) begin
      errors++; $display("FAIL wrap_second: got req=%b addr=%h pc_out=%h, expected 1 / 0 / 0",
                         bus_w.imem_req, bus_w.imem_addr, pc_out_w); end
    en = 1'b0; bus_w.imem_gnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_grant_hold();
    test_redirect();
    test_redirect_pop();
    test_reset_midburst();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_if_gen.md
PIPELINE_IF_GEN -- requirements
Module: pipeline_if_gen

Interface
REQ-001 Parameter XLEN, default 32: PC and instruction width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter PC_STEP, default 4: sequential PC increment in bytes.
REQ-004 Parameter FQ_DEPTH, default 2: fetch-queue depth and maximum outstanding memory requests; power of two, at least 2.
REQ-005 Ports: clk_IF input 1 clock. rst_IF input 1 reset, asynchronous, active-low. One clock domain only.
REQ-006 Ports: en_IF input 1 fetch enable. PCSrc input 1 redirect strobe. PC_in_IF input XLEN redirect target.
REQ-007 Ports: imem_req output 1. imem_addr output XLEN. imem_gnt input 1. imem_rvalid input 1. imem_rdata input XLEN.
REQ-008 Ports: id_valid output 1. id_ready input 1. id_pc output XLEN. id_inst output XLEN. PC_out_IF output XLEN, the current fetch PC.

Function
REQ-009 The fetch PC register SHALL drive both imem_addr and PC_out_IF.
REQ-010 Issue condition: imem_req SHALL assert when en_IF=1, PCSrc=0 and (outstanding + queue count) < FQ_DEPTH.
REQ-011 Once asserted, imem_req and imem_addr SHALL hold stable until imem_gnt=1, regardless of en_IF; the only exception is PCSrc.
REQ-012 On imem_req && imem_gnt: PC <= PC + PC_STEP, modulo 2^XLEN (wraps at all-ones); the request's PC is pushed to the pending-PC FIFO; outstanding increments.
REQ-013 Responses return in order, at least one cycle after grant. On imem_rvalid: the pending-PC FIFO pops and outstanding decrements; the entry {pc, imem_rdata} is pushed to the fetch queue unless the drop counter is nonzero.
REQ-014 imem_rvalid with outstanding=0 SHALL be ignored.
REQ-015 Redirect (PCSrc=1) takes effect on the next edge:
- PC <= {PC_in_IF[XLEN-1:2], 2'b00}.
- Fetch queue flushed.
- Drop counter <= outstanding, plus 1 if a grant occurs in the same cycle, minus 1 if an imem_rvalid occurs in the same cycle.
- imem_req = 0 in the PCSrc cycle.
REQ-016 Each dropped response SHALL decrement the drop counter and SHALL NOT reach the queue.
REQ-017 id_valid SHALL equal "queue non-empty". id_pc and id_inst SHALL show the head entry. Pop on id_valid && id_ready.
REQ-018 Simultaneous push and pop SHALL keep the count unchanged. The issue credit of REQ-010 SHALL guarantee the queue never overflows.
REQ-019 Priority: redirect over pop and push. A pop in the PCSrc cycle is discarded and id_valid = 0 in the following cycle.
REQ-020 Best-case latency: grant in cycle N, rvalid in N+1, id_valid in N+2.
REQ-021 With en_IF=0 and no pending request: PC, imem_req and the issue logic SHALL freeze. Responses and pops SHALL continue.

Reset
REQ-022 While rst_IF=0, asynchronously:
- PC = RESET_PC.
- imem_req = 0.
- id_valid = 0.
- id_pc and id_inst = 0.
- Queue, pending-PC FIFO, outstanding and drop counter cleared.
REQ-023 Reset mid-transaction SHALL abandon in-flight requests. Late responses after release are ignored per REQ-014.
REQ-024 First imem_req SHALL assert in the first cycle after release with en_IF=1, carrying imem_addr = RESET_PC.

Structure
REQ-025 Package pipeline_if_pkg SHALL hold XLEN, RESET_PC and PC_STEP defaults and the fetch-entry struct {pc, inst}.
REQ-026 Sub-module if_fifo SHALL be a synchronous FIFO (depth and width parameters, flush input, count output).
REQ-027 pipeline_if_gen SHALL instantiate if_fifo twice: pending-PC FIFO and fetch queue.
REQ-028 All state SHALL be in pipeline_if_gen or if_fifo; no latches.

Verification
REQ-029 Streaming: release reset, en_IF=1, gnt=1 every cycle, rvalid one cycle later, id_ready=1 -> id_pc sequence 0,4,8,12 on consecutive cycles, id_inst matching the returned data.
REQ-030 Backpressure: id_ready=0 for 6 cycles, FQ_DEPTH=2 -> exactly 2 grants, then imem_req=0. Releasing id_ready resumes fetch at PC 8 with no loss or duplicate.
REQ-031 Redirect with 2 outstanding:
- Stimulus: PCSrc=1, PC_in_IF=32'h0000_1003.
- Both stale responses dropped.
- Next imem_addr = 32'h0000_1000.
- First id_pc after the redirect = 32'h0000_1000.
REQ-032 Grant hold: gnt=0 for 3 cycles while en_IF toggles -> imem_req stays high, imem_addr stable at 0, PC_out_IF unchanged.
REQ-033 Wrap and reset:
- RESET_PC = 32'hFFFF_FFFC -> second request address 32'h0000_0000.
- Assert rst_IF low mid-burst -> all outputs at reset values immediately.
- A late rvalid after release -> ignored, id_valid stays 0.
